// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel runtime-programmable clock divider
// Divisor updates are staged in pending registers and swapped in only at a period boundary.
module clk_div_prog #(
    parameter int CH          = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic             sync_restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEFAULT_DIV >> 1);

    logic [DIV_W-1:0] div_q   [CH];
    logic [DIV_W-1:0] high_q  [CH];
    logic [DIV_W-1:0] pdiv_q  [CH];
    logic [DIV_W-1:0] phigh_q [CH];
    logic [DIV_W-1:0] cnt_q   [CH];
    logic [DIV_W-1:0] nxt     [CH];
    logic [CH-1:0]    pend_q;

    logic [CH-1:0]    wrap;
    logic [CH-1:0]    apply_cfg;
    logic [CH-1:0]    wr_sel;
    logic             cfg_in_range;
    logic [DIV_W-1:0] cfg_div_eff;
    logic [DIV_W-1:0] cfg_high_lo;
    logic [DIV_W-1:0] cfg_high_eff;

    // Out-of-range channel writes are handshaked normally and then dropped.
    always_comb begin
        cfg_in_range = 32'(cfg_ch) < 32'(CH);
        cfg_ready    = cfg_in_range ? ~pend_q[cfg_ch] : 1'b1;
    end

    always_comb begin
        cfg_div_eff  = (cfg_div < TWO) ? TWO : cfg_div;
        cfg_high_lo  = (cfg_high == '0) ? ONE : cfg_high;
        cfg_high_eff = (cfg_high_lo > cfg_div_eff - ONE) ? (cfg_div_eff - ONE) : cfg_high_lo;
    end

    // A pending config only ever comes from an earlier accept, so apply and write never collide.
    always_comb begin
        wrap      = '0;
        apply_cfg = '0;
        wr_sel    = '0;
        for (int i = 0; i < CH; i++) begin
            nxt[i]       = (cnt_q[i] == div_q[i] - ONE) ? '0 : cnt_q[i] + ONE;
            wrap[i]      = en[i] && !sync_restart && (cnt_q[i] == div_q[i] - ONE);
            apply_cfg[i] = pend_q[i] && (sync_restart || !en[i] || wrap[i]);
            wr_sel[i]    = cfg_valid && cfg_ready && cfg_in_range && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                div_q[i]   <= RST_DIV;
                high_q[i]  <= RST_HIGH;
                pdiv_q[i]  <= RST_DIV;
                phigh_q[i] <= RST_HIGH;
                cnt_q[i]   <= '0;
            end
            pend_q  <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync_restart || !en[i]) begin
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else begin
                    cnt_q[i]   <= nxt[i];
                    clk_out[i] <= (nxt[i] < high_q[i]);
                    tick[i]    <= (nxt[i] == '0);
                end

                if (apply_cfg[i]) begin
                    div_q[i]  <= pdiv_q[i];
                    high_q[i] <= phigh_q[i];
                    pend_q[i] <= 1'b0;
                end else if (wr_sel[i]) begin
                    pdiv_q[i]  <= cfg_div_eff;
                    phigh_q[i] <= cfg_high_eff;
                    pend_q[i]  <= 1'b1;
                end
            end
        end
    end

endmodule
